// File: rtl/run_pattern_pkg.sv
// rtl/run_pattern_pkg.sv - shared state encoding and default widths for the run pattern generator and detector
package run_pattern_pkg;

    localparam int LEN_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/run_len_counter.sv
// rtl/run_len_counter.sv - in-run clock counter with length load, clear and terminal-count flag
module run_len_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             tc
);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] last_q, last_d;

    // A zero length behaves as a one-clock run, so the terminal value is then 0.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (load) begin
            cnt_d  = '0;
            last_d = (len == '0) ? '0 : len - LEN_W'(1);
        end else if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign tc = (cnt_q == last_q);

endmodule

// File: rtl/run_pattern_gen.sv
// rtl/run_pattern_gen.sv - alternating-level run pattern transmitter; optional mark output via RUN_PATTERN_MARK_EN
module run_pattern_gen #(
    parameter int   LEN_W      = run_pattern_pkg::LEN_W,
    parameter int   CNT_W      = run_pattern_pkg::CNT_W,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    input  logic [CNT_W-1:0] num_runs,
    output logic             x,
    output logic             busy,
    output logic             done
`ifdef RUN_PATTERN_MARK_EN
    ,
    output logic             mark
`endif
);

    import run_pattern_pkg::*;

    state_t           state_q, state_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] runs_q, runs_d;
    logic [CNT_W-1:0] num_runs_q, num_runs_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_clear, cnt_inc;
    logic             tc;
    logic [CNT_W-1:0] runs_inc;

    run_len_counter #(
        .LEN_W (LEN_W)
    ) u_run_len_counter (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .len   (run_len),
        .tc    (tc)
    );

    assign runs_inc = runs_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        runs_d     = runs_q;
        num_runs_d = num_runs_q;
        cnt_load   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_load   = 1'b1;
                    num_runs_d = num_runs;
                    runs_d     = '0;
                    level_d    = 1'b0;
                    state_d    = (num_runs == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (tc) begin
                    cnt_clear = 1'b1;
                    level_d   = ~level_q;
                    runs_d    = runs_inc;
                    if (runs_inc == num_runs_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one clock.
    always_comb begin
        x_d    = (state_q == ST_RUN) ? level_q : IDLE_LEVEL;
        busy_d = (state_q != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

`ifdef RUN_PATTERN_MARK_EN
    logic mark_q, mark_d;

    always_comb begin
        mark_d = (state_q == ST_RUN) && tc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mark_q <= 1'b0;
        end else begin
            mark_q <= mark_d;
        end
    end

    assign mark = mark_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            level_q    <= 1'b0;
            runs_q     <= '0;
            num_runs_q <= '0;
            x_q        <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            runs_q     <= runs_d;
            num_runs_q <= num_runs_d;
            x_q        <= x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// tb/tb_run_pattern_gen.sv - self-checking bench for run_pattern_gen against a per-cycle output queue model
module tb_run_pattern_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] run_len;
    logic [7:0] num_runs;
    logic       x, busy, done;
`ifdef RUN_PATTERN_MARK_EN
    logic       mark;
`endif

    int errors = 0;
    int checks = 0;

    run_pattern_gen dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .run_len  (run_len),
        .num_runs (num_runs),
        .x        (x),
        .busy     (busy),
        .done     (done)
`ifdef RUN_PATTERN_MARK_EN
        ,
        .mark     (mark)
`endif
    );

    always #5 clock = ~clock;

    // Expected outputs packed as {x, busy, done, mark}.
    localparam logic [3:0] IDLE_O = 4'b1000;
    logic [3:0] mq[$];
    logic [3:0] exp_o = IDLE_O;
    bit         acc;
    int         m_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Each accepted start queues the whole output sequence: len clocks per run, then one done cycle.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            exp_o = IDLE_O;
        end else begin
            acc   = (mq.size() == 0) && (start === 1'b1);
            exp_o = (mq.size() != 0) ? mq.pop_front() : IDLE_O;
            if (acc) begin
                m_len = (run_len == 0) ? 1 : int'(run_len);
                for (int r = 0; r < int'(num_runs); r++) begin
                    for (int c = 0; c < m_len; c++) begin
                        mq.push_back({r[0], 1'b1, 1'b0, (c == m_len - 1)});
                    end
                end
                mq.push_back(4'b1110);
            end
        end
    end

    always @(negedge clock) begin
        check("x", x, exp_o[3]);
        check("busy", busy, exp_o[2]);
        check("done", done, exp_o[1]);
`ifdef RUN_PATTERN_MARK_EN
        check("mark", mark, exp_o[0]);
`endif
    end

    task automatic run_seq(input logic [3:0] len, input logic [7:0] n, input int poke_at,
                           output logic [63:0] xs, output logic [63:0] ms,
                           output int nx, output int nd, output int nb, output int nm);
        xs = '0; ms = '0; nx = 0; nd = 0; nb = 0; nm = 0;
        start    = 1'b1;
        run_len  = len;
        num_runs = n;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 300 && nd == 0; i++) begin
            if (i > 0) @(negedge clock);
            if (busy) nb++;
            if (done) nd++;
            else if (busy) begin
                xs = {xs[62:0], x};
`ifdef RUN_PATTERN_MARK_EN
                ms = {ms[62:0], mark};
`endif
                nx++;
            end
            if (exp_o[0]) nm++;
            if (i == poke_at) begin
                start = 1'b1; run_len = 4'd2; num_runs = 8'd5;
            end
            if (i == poke_at + 2) begin
                start = 1'b0; run_len = 4'd9; num_runs = 8'd1;
            end
        end
        start = 1'b0;
        if (nd == 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    logic [63:0] xs, ms;
    int nx, nd, nb, nm;
    logic [19:0] bb;

    initial begin
        reset = 1'b1; start = 1'b0; run_len = '0; num_runs = '0;
        repeat (2) @(negedge clock);
        check("rst_x", x, 1); check("rst_busy", busy, 0); check("rst_done", done, 0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check("idle_x", x, 1); check("idle_busy", busy, 0);
        end

        run_seq(4'd4, 8'd3, -1, xs, ms, nx, nd, nb, nm);
        check("p43_x", xs[11:0], 12'b0000_1111_0000);
        check("p43_len", nx, 12); check("p43_busy", nb, 13); check("p43_marks", nm, 3);
        @(negedge clock);
        check("p43_after_x", x, 1); check("p43_after_done", done, 0);

        run_seq(4'd0, 8'd2, -1, xs, ms, nx, nd, nb, nm);
        check("p02_x", xs[1:0], 2'b01); check("p02_len", nx, 2);
        @(negedge clock);

        run_seq(4'd5, 8'd0, -1, xs, ms, nx, nd, nb, nm);
        check("p50_len", nx, 0); check("p50_busy", nb, 1); check("p50_done", nd, 1);
        @(negedge clock);

        run_seq(4'd4, 8'd2, -1, xs, ms, nx, nd, nb, nm);
        check("p42_marks", nm, 2);
`ifdef RUN_PATTERN_MARK_EN
        check("p42_mark_pos", ms[7:0], 8'b0001_0001);
`endif
        @(negedge clock);

        run_seq(4'd4, 8'd3, 3, xs, ms, nx, nd, nb, nm);
        check("repulse_x", xs[11:0], 12'b0000_1111_0000);
        check("repulse_len", nx, 12);
        repeat (4) @(negedge clock);

        start = 1'b1; run_len = 4'd4; num_runs = 8'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_x", x, 1); check("midrst_busy", busy, 0); check("midrst_done", done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clock);
            check("midrst_nodone", done, 0);
        end

        start = 1'b1; run_len = 4'd1; num_runs = 8'd2;
        nd = 0; bb = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            bb = {bb[18:0], x};
            if (done) nd++;
        end
        check("b2b_x", bb, 20'hBBBBB); check("b2b_dones", nd, 5);
        start = 1'b0;
        repeat (6) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_pattern_gen.md
# run_pattern_gen

Serial run-length pattern transmitter: on a start request it drives a single-bit line `x` with a programmed number of runs, alternating level each run, every run held for a programmed number of clocks. It is the source side of the run-length detector FSM: it generates the stimulus stream that the detector samples. It sits between a control register or bench sequencer and the detector's `x` input.

## Interface
- `LEN_W`, 4: width of `run_len`; maximum run length is 2^LEN_W−1 clocks.
- `CNT_W`, 8: width of `num_runs` and the internal run counter.
- `IDLE_LEVEL`, 1'b1: level of `x` while not transmitting.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; forces the idle state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `run_len`  in  LEN_W  clocks per run; latched on accepted start.
- `num_runs`  in  CNT_W  number of runs to send; latched on accepted start.
- `x`  out  1  serial pattern output, registered.
- `busy`  out  1  high from the cycle after start is accepted until DONE is left.
- `done`  out  1  one-cycle pulse after the last run completes.
- `mark`  out  1  present only with `RUN_PATTERN_MARK_EN` (see Configuration).

## Operation
- States: IDLE, RUN, DONE (Moore; outputs are functions of registered state only).
- IDLE: `x`=IDLE_LEVEL, `busy`=0, `done`=0. `start`=1 latches `run_len` and `num_runs`, clears the in-run counter and run counter, and sets level to 0.
  - Latched `num_runs`=0 → go to DONE directly; no run is emitted.
  - Otherwise → RUN.
- Latched `run_len`=0 is treated as 1.
- RUN: `x`=current level, `busy`=1. The in-run counter increments each clock. When it equals len−1:
  - level toggles and the in-run counter clears;
  - the run counter increments;
  - if the run counter then equals `num_runs`, go to DONE.
- DONE: `x`=IDLE_LEVEL, `busy`=1, `done`=1 for exactly one cycle, then IDLE.
- The first run is always level 0, so runs alternate 0,1,0,1…
- `start` is ignored outside IDLE. Input changes after latching have no effect.
- Counter compares use full width; there is no wrap. The maximum run count is 2^CNT_W−1.

## Timing
- Reset values: `x`=IDLE_LEVEL, `busy`=0, `done`=0, `mark`=0, state IDLE, all counters 0.
- `start` accepted at edge k → `x` shows the first run level from after edge k+1. Total transmit time is `num_runs`×len clocks. `done` is high during the single cycle after the last run cycle.
- `start` held high through DONE → re-accepted on the first IDLE cycle. Back-to-back sequences have exactly one DONE and one IDLE cycle between them.
- Reset asserted mid-RUN → all outputs return to their reset values asynchronously. No `done` pulse is produced. The partial sequence is discarded.
- Reset release coincident with `start` → `start` is ignored until the first full clock edge after deassertion.

## Configuration
- `RUN_PATTERN_MARK_EN` defined: output `mark` is high during the last clock of every run, i.e. the in-run counter equals len−1 in RUN. This is the cycle on which a matched detector raises its output. Use it as the bench's expected-output reference.
- `RUN_PATTERN_MARK_EN` undefined: the `mark` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `run_pattern_pkg`: state enum (IDLE, RUN, DONE) and the default widths `LEN_W` and `CNT_W`. The detector bench imports the same package.
- One sub-module: `run_len_counter`.
  - Contents: the in-run counter with load/clear and its terminal-count output `tc`.
  - Parameterized by LEN_W.
  - The top level holds the FSM, level register and run counter.

## Test plan
- Reset, then idle 5 cycles → `x`=1, `busy`=0, `done`=0 throughout.
- `run_len`=4, `num_runs`=3, pulse start → `x` = 0000 1111 0000 (12 cycles), then `done` pulses once and `x` returns to 1.
- `run_len`=0, `num_runs`=2 → runs of 1 clock, `x` = 0,1, then `done`.
- `num_runs`=0 → no run, `done` pulses on the cycle after start, `busy` high for that cycle only.
- Start re-pulsed mid-RUN with different values → ignored, original pattern completes. Reset asserted on cycle 6 of a 12-cycle pattern → outputs go to reset values immediately, no `done`.
- With `RUN_PATTERN_MARK_EN`, `run_len`=4, `num_runs`=2 → `mark` high on pattern cycles 4 and 8 only. A connected detector's `y` matches `mark`.
